// File: rtl/seq_pkg.sv
// Shared types and sizing helpers for the test sequencer.
package seq_pkg;

    localparam int unsigned MAX_TESTS = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        RUN     = 3'd2,
        RELEASE = 3'd3,
        FINISH  = 3'd4
    } seq_state_e;

    // Width of a test index; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter able to hold 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/timeout_counter.sv
// Per-test cycle counter; flags the cycle whose edge completes the limit-th counted cycle.
module timeout_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables expiry entirely.
    assign expired = en && (limit != '0) && (cnt_d == limit);

endmodule

// File: rtl/test_sequencer.sv
// Walks enabled test channels in index order, starting each one and collecting
// its pass/fail/timeout verdict.
module test_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned  NUM_TESTS    = 4,
    parameter int unsigned  TIMEOUT_W    = 16,
    parameter bit           STOP_ON_FAIL = 1'b0,
    localparam int unsigned IDX_W        = idx_w(NUM_TESTS),
    localparam int unsigned CNT_W        = cnt_w(NUM_TESTS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 go_i,
    input  logic [NUM_TESTS-1:0] test_mask_i,
    input  logic [TIMEOUT_W-1:0] timeout_i,
    output logic [NUM_TESTS-1:0] start_o,
    input  logic [NUM_TESTS-1:0] done_i,
    input  logic [NUM_TESTS-1:0] fail_i,
    output logic                 busy_o,
    output logic                 finished_o,
    output logic [NUM_TESTS-1:0] pass_o,
    output logic [NUM_TESTS-1:0] failed_o,
    output logic [NUM_TESTS-1:0] timed_out_o,
    output logic [CNT_W-1:0]     pass_count_o,
    output logic [IDX_W-1:0]     cur_idx_o
);

    seq_state_e           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_TESTS-1:0] mask_q, mask_d;
    logic [TIMEOUT_W-1:0] limit_q, limit_d;
    logic [NUM_TESTS-1:0] pass_q, pass_d;
    logic [NUM_TESTS-1:0] failed_q, failed_d;
    logic [NUM_TESTS-1:0] to_q, to_d;
    logic [CNT_W-1:0]     pc_q, pc_d;
    logic [NUM_TESTS-1:0] start_q, start_d;
    logic                 busy_q, busy_d;
    logic                 fin_q, fin_d;

    logic last_c;
    logic cnt_clr;
    logic cnt_en;
    logic expired;

    assign last_c  = (idx_q == IDX_W'(NUM_TESTS - 1));
    // Every RUN is preceded by SELECT, so clearing there gives a fresh count on entry.
    assign cnt_clr = (state_q == SELECT);
    assign cnt_en  = (state_q == RUN);

    timeout_counter #(
        .W(TIMEOUT_W)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (limit_q),
        .expired (expired)
    );

    // Next-state and next-result logic.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        limit_d  = limit_q;
        pass_d   = pass_q;
        failed_d = failed_q;
        to_d     = to_q;
        pc_d     = pc_q;

        case (state_q)
            IDLE: begin
                if (go_i) begin
                    mask_d   = test_mask_i;
                    limit_d  = timeout_i;
                    pass_d   = '0;
                    failed_d = '0;
                    to_d     = '0;
                    pc_d     = '0;
                    idx_d    = '0;
                    state_d  = SELECT;
                end
            end
            SELECT: begin
                if (mask_q[idx_q]) begin
                    state_d = RUN;
                end else if (last_c) begin
                    state_d = FINISH;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            RUN: begin
                // A done arriving on the expiry cycle takes precedence.
                if (done_i[idx_q]) begin
                    if (fail_i[idx_q]) begin
                        failed_d[idx_q] = 1'b1;
                    end else begin
                        pass_d[idx_q] = 1'b1;
                        pc_d          = pc_q + CNT_W'(1);
                    end
                    state_d = RELEASE;
                end else if (expired) begin
                    to_d[idx_q]     = 1'b1;
                    failed_d[idx_q] = 1'b1;
                    state_d         = RELEASE;
                end
            end
            RELEASE: begin
                if (!done_i[idx_q]) begin
                    if ((STOP_ON_FAIL && failed_q[idx_q]) || last_c) begin
                        state_d = FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = SELECT;
                    end
                end
            end
            FINISH: begin
                if (!go_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_d = (state_d == RUN) ? (NUM_TESTS'(1) << idx_d) : '0;
        busy_d  = (state_d == SELECT) || (state_d == RUN) || (state_d == RELEASE);
        fin_d   = (state_d == FINISH);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            mask_q   <= '0;
            limit_q  <= '0;
            pass_q   <= '0;
            failed_q <= '0;
            to_q     <= '0;
            pc_q     <= '0;
            start_q  <= '0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            limit_q  <= limit_d;
            pass_q   <= pass_d;
            failed_q <= failed_d;
            to_q     <= to_d;
            pc_q     <= pc_d;
            start_q  <= start_d;
            busy_q   <= busy_d;
            fin_q    <= fin_d;
        end
    end

    assign start_o      = start_q;
    assign busy_o       = busy_q;
    assign finished_o   = fin_q;
    assign pass_o       = pass_q;
    assign failed_o     = failed_q;
    assign timed_out_o  = to_q;
    assign pass_count_o = pc_q;
    assign cur_idx_o    = idx_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Bench for test_sequencer: two instances (STOP_ON_FAIL 0 and 1) driven by responsive
// test models and checked each cycle against a run timeline computed from the rules.
`timescale 1ns/1ps
module tb_test_sequencer;

    localparam int N    = 4;
    localparam int TW   = 16;
    localparam int MAXC = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          go;
    logic [N-1:0]  mask;
    logic [TW-1:0] tmo;

    logic [N-1:0]  done_v    [2];
    logic [N-1:0]  fail_v    [2];
    logic [N-1:0]  start_v   [2];
    logic [N-1:0]  pass_v    [2];
    logic [N-1:0]  failed_v  [2];
    logic [N-1:0]  to_v      [2];
    logic          busy_v    [2];
    logic          fin_v     [2];
    logic [2:0]    pc_v      [2];
    logic [1:0]    idx_v     [2];

    always #5 clk = ~clk;

    test_sequencer #(.NUM_TESTS(N), .TIMEOUT_W(TW), .STOP_ON_FAIL(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .go_i(go), .test_mask_i(mask), .timeout_i(tmo),
        .start_o(start_v[0]), .done_i(done_v[0]), .fail_i(fail_v[0]),
        .busy_o(busy_v[0]), .finished_o(fin_v[0]), .pass_o(pass_v[0]),
        .failed_o(failed_v[0]), .timed_out_o(to_v[0]), .pass_count_o(pc_v[0]),
        .cur_idx_o(idx_v[0])
    );

    test_sequencer #(.NUM_TESTS(N), .TIMEOUT_W(TW), .STOP_ON_FAIL(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .go_i(go), .test_mask_i(mask), .timeout_i(tmo),
        .start_o(start_v[1]), .done_i(done_v[1]), .fail_i(fail_v[1]),
        .busy_o(busy_v[1]), .finished_o(fin_v[1]), .pass_o(pass_v[1]),
        .failed_o(failed_v[1]), .timed_out_o(to_v[1]), .pass_count_o(pc_v[1]),
        .cur_idx_o(idx_v[1])
    );

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Test-channel behaviour: done rises in the lat-th cycle of start, drops when start drops.
    int lat  [N];
    bit fl   [N];
    bit hang [N];
    int rc   [2][N];

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < N; i++) begin
                if (start_v[d][i]) begin
                    rc[d][i]     = rc[d][i] + 1;
                    done_v[d][i] = !hang[i] && (rc[d][i] >= lat[i]);
                    fail_v[d][i] = done_v[d][i] && fl[i];
                end else begin
                    rc[d][i]     = 0;
                    done_v[d][i] = 1'b0;
                    fail_v[d][i] = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected outputs per cycle offset from the go edge, for each instance.
    logic [N-1:0] e_start [2][MAXC];
    logic [N-1:0] e_pass  [2][MAXC];
    logic [N-1:0] e_fail  [2][MAXC];
    logic [N-1:0] e_to    [2][MAXC];
    logic         e_busy  [2][MAXC];
    logic         e_finv  [2][MAXC];
    logic [1:0]   e_idx   [2][MAXC];
    logic [2:0]   e_pc    [2][MAXC];
    int           e_fin   [2];

    function automatic void build(input int d);
        bit stop;
        int t, fin, dur, pc, ix;
        int v [N];
        int s [N];
        int e [N];
        bit vis [N];
        bit ran [N];
        bit ok  [N];
        bit th  [N];
        logic [N-1:0] st, ps, fa, tt;
        stop = (d == 1);
        t = 0;
        fin = -1;
        for (int i = 0; i < N; i++) begin
            v[i] = 0; s[i] = 0; e[i] = 0; vis[i] = 0; ran[i] = 0; ok[i] = 0; th[i] = 0;
        end
        for (int i = 0; i < N && fin < 0; i++) begin
            vis[i] = 1;
            v[i]   = t;
            if (!mask[i]) begin
                if (i == N - 1) fin = t + 1;
                else            t = t + 1;
            end else begin
                th[i]  = (tmo != 0) && (hang[i] || lat[i] > int'(tmo));
                dur    = th[i] ? int'(tmo) : lat[i];
                ok[i]  = !th[i] && !fl[i];
                ran[i] = 1;
                s[i]   = t + 1;
                e[i]   = t + 1 + dur;
                if ((stop && !ok[i]) || i == N - 1) fin = e[i] + 1;
                else                                t = e[i] + 1;
            end
        end
        e_fin[d] = fin;
        for (int c = 0; c < MAXC; c++) begin
            st = '0; ps = '0; fa = '0; tt = '0; pc = 0; ix = 0;
            for (int i = 0; i < N; i++) begin
                if (vis[i] && v[i] <= c) ix = i;
                if (ran[i] && s[i] <= c && c < e[i]) st[i] = 1'b1;
                if (ran[i] && e[i] <= c) begin
                    if (ok[i]) begin
                        ps[i] = 1'b1;
                        pc++;
                    end else begin
                        fa[i] = 1'b1;
                    end
                    if (th[i]) tt[i] = 1'b1;
                end
            end
            e_start[d][c] = st;
            e_pass[d][c]  = ps;
            e_fail[d][c]  = fa;
            e_to[d][c]    = tt;
            e_busy[d][c]  = (c < fin);
            e_finv[d][c]  = (c == fin);
            e_idx[d][c]   = 2'(ix);
            e_pc[d][c]    = 3'(pc);
        end
    endfunction

    logic         chk_on = 1'b0;
    int           g_edge = 0;
    logic [N-1:0] seen [2];
    int           fin_off [2];
    int           s2cnt;

    // Per-cycle comparison against the timeline.
    always @(negedge clk) begin
        int c;
        if (chk_on) begin
            c = cyc - g_edge;
            if (c >= 0 && c < MAXC) begin
                if (c == 0) begin
                    seen[0] = '0; seen[1] = '0;
                    fin_off[0] = -1; fin_off[1] = -1;
                    s2cnt = 0;
                end
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("d%0d c%0d start", d, c), 32'(start_v[d]), 32'(e_start[d][c]));
                    chk($sformatf("d%0d c%0d busy", d, c), 32'(busy_v[d]), 32'(e_busy[d][c]));
                    chk($sformatf("d%0d c%0d finished", d, c), 32'(fin_v[d]), 32'(e_finv[d][c]));
                    chk($sformatf("d%0d c%0d cur_idx", d, c), 32'(idx_v[d]), 32'(e_idx[d][c]));
                    chk($sformatf("d%0d c%0d pass", d, c), 32'(pass_v[d]), 32'(e_pass[d][c]));
                    chk($sformatf("d%0d c%0d failed", d, c), 32'(failed_v[d]), 32'(e_fail[d][c]));
                    chk($sformatf("d%0d c%0d timed_out", d, c), 32'(to_v[d]), 32'(e_to[d][c]));
                    chk($sformatf("d%0d c%0d pass_count", d, c), 32'(pc_v[d]), 32'(e_pc[d][c]));
                    seen[d] = seen[d] | start_v[d];
                    if (fin_off[d] < 0 && fin_v[d]) fin_off[d] = c;
                end
                if (start_v[0][2]) s2cnt++;
            end
        end
    end

    task automatic set_cfg(input int l, input int hang_idx, input int fail_idx);
        for (int i = 0; i < N; i++) begin
            lat[i]  = l;
            hang[i] = (i == hang_idx);
            fl[i]   = (i == fail_idx);
        end
    endtask

    task automatic run_scn(input int glitch);
        int win;
        build(0);
        build(1);
        win = ((e_fin[0] > e_fin[1]) ? e_fin[0] : e_fin[1]) + 4;
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        g_edge = cyc;
        go     = 1'b0;
        chk_on = 1'b1;
        // Inputs are latched at run start, so later changes must have no effect.
        mask = ~mask;
        tmo  = tmo + TW'(7);
        for (int k = 1; k < win; k++) begin
            @(posedge clk);
            #1;
            go = (k == glitch);
        end
        @(posedge clk);
        #1;
        chk_on = 1'b0;
        go     = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s d%0d start", tag, d), 32'(start_v[d]), 32'h0);
            chk($sformatf("%s d%0d busy", tag, d), 32'(busy_v[d]), 32'h0);
            chk($sformatf("%s d%0d finished", tag, d), 32'(fin_v[d]), 32'h0);
            chk($sformatf("%s d%0d results", tag, d),
                32'({pass_v[d], failed_v[d], to_v[d]}), 32'h0);
            chk($sformatf("%s d%0d pass_count", tag, d), 32'(pc_v[d]), 32'h0);
            chk($sformatf("%s d%0d cur_idx", tag, d), 32'(idx_v[d]), 32'h0);
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        go      = 1'b0;
        mask    = '0;
        tmo     = '0;
        set_cfg(3, -1, -1);

        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("idle");

        // All four pass, go pulsed mid-run is ignored.
        mask = 4'hF; tmo = '0; set_cfg(3, -1, -1);
        run_scn(8);
        chk("A pass_o", 32'(pass_v[0]), 32'hF);
        chk("A pass_count", 32'(pc_v[0]), 32'd4);
        chk("A finish offset", 32'(fin_off[0]), 32'd20);

        // Masked tests never start.
        mask = 4'b0101; tmo = '0; set_cfg(1, -1, -1);
        lat[0] = 2; lat[2] = 4;
        run_scn(-1);
        chk("B pass_o", 32'(pass_v[0]), 32'h5);
        chk("B pass_count", 32'(pc_v[0]), 32'd2);
        chk("B masked starts", 32'(seen[0] & 4'b1010), 32'h0);

        // Test 2 hangs, timeout 5.
        mask = 4'hF; tmo = TW'(5); set_cfg(2, 2, -1);
        run_scn(-1);
        chk("C timed_out_o", 32'(to_v[0]), 32'h4);
        chk("C failed_o", 32'(failed_v[0]), 32'h4);
        chk("C start2 cycles", 32'(s2cnt), 32'd5);
        chk("C pass_o", 32'(pass_v[0]), 32'hB);
        chk("C stop failed_o", 32'(failed_v[1]), 32'h4);

        // Test 1 fails; the stopping instance must not visit tests 2 and 3.
        mask = 4'hF; tmo = '0; set_cfg(2, -1, 1);
        run_scn(-1);
        chk("D failed_o", 32'(failed_v[0]), 32'h2);
        chk("D pass_o", 32'(pass_v[0]), 32'hD);
        chk("D stop failed_o", 32'(failed_v[1]), 32'h2);
        chk("D stop pass_count", 32'(pc_v[1]), 32'd1);
        chk("D stop late starts", 32'(seen[1] & 4'b1100), 32'h0);

        // Done on the same cycle as expiry: done wins.
        mask = 4'b0001; tmo = TW'(4); set_cfg(4, -1, -1);
        run_scn(-1);
        chk("E pass_o", 32'(pass_v[0]), 32'h1);
        chk("E timed_out_o", 32'(to_v[0]), 32'h0);

        // One cycle later than the limit: timeout.
        mask = 4'b0001; tmo = TW'(4); set_cfg(5, -1, -1);
        run_scn(-1);
        chk("E2 timed_out_o", 32'(to_v[0]), 32'h1);
        chk("E2 pass_o", 32'(pass_v[0]), 32'h0);

        // Empty mask.
        mask = 4'b0000; tmo = '0; set_cfg(2, -1, -1);
        run_scn(-1);
        chk("F finish offset", 32'(fin_off[0]), 32'd4);
        chk("F results", 32'({pass_v[0], failed_v[0], to_v[0]}), 32'h0);

        // Reset while test 2 is running.
        mask = 4'hF; tmo = '0; set_cfg(2, 2, -1);
        @(negedge clk);
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        n  = 0;
        while (start_v[0][2] !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("H reached test2", 32'(start_v[0][2]), 32'h1);
        chk("H partial pass", 32'(pass_v[0]), 32'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("H async");
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("H idle");

        // Sequencer usable again after reset.
        mask = 4'hF; tmo = '0; set_cfg(3, -1, -1);
        run_scn(-1);
        chk("R pass_o", 32'(pass_v[0]), 32'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
